// File: rtl/wisc_flags_pkg.sv
// Shared constants for the condition-flag controller: opcodes, branch conditions,
// flag bit positions and the hazard FSM state type.
package wisc_flags_pkg;

    localparam logic [3:0] OPC_ADD = 4'b0000;
    localparam logic [3:0] OPC_SUB = 4'b0001;
    localparam logic [3:0] OPC_XOR = 4'b0010;
    localparam logic [3:0] OPC_SLL = 4'b0100;
    localparam logic [3:0] OPC_SRA = 4'b0101;
    localparam logic [3:0] OPC_ROR = 4'b0110;

    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OV     = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator: (condition code, {N,V,Z}) -> taken.
module br_cond_eval
    import wisc_flags_pkg::*;
#(
    parameter int unsigned COND_W = 3
) (
    input  logic [COND_W-1:0] cond,
    input  logic [2:0]        flags,
    output logic              taken
);

    logic z, v, n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_W'(COND_NE):     taken = !z;
            COND_W'(COND_EQ):     taken = z;
            COND_W'(COND_GT):     taken = !z && !n;
            COND_W'(COND_LT):     taken = n;
            COND_W'(COND_GE):     taken = z || !n;
            COND_W'(COND_LE):     taken = n || z;
            COND_W'(COND_OV):     taken = v;
            COND_W'(COND_UNCOND): taken = 1'b1;
            default:              taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_ctrl.sv
// Condition-flag owner: EX write-enable decode, flag commit, ID branch resolution and
// flag RAW hazard handling. Define FLAG_CTRL_FWD_EN to forward EX flags instead of stalling.
module flag_ctrl
    import wisc_flags_pkg::*;
#(
    parameter int unsigned OPC_W    = 4,
    parameter int unsigned COND_W   = 3,
    parameter logic [2:0]  FLAG_RST = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_stall,
    input  logic              ex_valid,
    input  logic [OPC_W-1:0]  ex_opcode,
    input  logic [2:0]        ex_flags_in,
    input  logic              id_br_valid,
    input  logic [COND_W-1:0] id_br_cond,
    output logic [2:0]        flag_current,
    output logic [2:0]        flag_wen,
    output logic              br_resolved,
    output logic              br_taken,
    output logic              hazard_stall
);

    state_t     state;
    logic [2:0] flag_q;
    logic [2:0] wen;
    logic [2:0] eff_flags;
    logic [2:0] eval_flags;
    logic       hazard;
    logic       stall_req;
    logic       eval_taken;

    always_comb begin
        wen = '0;
        if (ex_valid && !pipe_stall) begin
            case (ex_opcode)
                OPC_W'(OPC_ADD), OPC_W'(OPC_SUB): wen = 3'b111;
                OPC_W'(OPC_XOR), OPC_W'(OPC_SLL),
                OPC_W'(OPC_SRA), OPC_W'(OPC_ROR): wen = 3'b001;
                default:                          wen = 3'b000;
            endcase
        end
    end

    // Coarse on purpose: any flag write collides with any non-unconditional branch.
    assign hazard = id_br_valid && (id_br_cond != COND_W'(COND_UNCOND)) && (|wen);

`ifdef FLAG_CTRL_FWD_EN
    assign eff_flags = (ex_flags_in & wen) | (flag_q & ~wen);
    assign stall_req = 1'b0;
`else
    assign eff_flags = flag_q;
    assign stall_req = hazard;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= FLAG_RST;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (wen[i]) flag_q[i] <= ex_flags_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (stall_req) state <= WAIT;
                WAIT:    if (!pipe_stall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // In WAIT the stalled branch's flags are already committed, so evaluate the register.
    assign eval_flags = (state == WAIT) ? flag_q : eff_flags;

    br_cond_eval #(
        .COND_W(COND_W)
    ) u_br_cond_eval (
        .cond  (id_br_cond),
        .flags (eval_flags),
        .taken (eval_taken)
    );

    always_comb begin
        flag_wen     = wen;
        hazard_stall = 1'b0;
        br_resolved  = 1'b0;
        br_taken     = 1'b0;
        case (state)
            IDLE: begin
                if (stall_req) begin
                    hazard_stall = 1'b1;
                end else begin
                    br_resolved = id_br_valid;
                    br_taken    = id_br_valid && eval_taken;
                end
            end
            WAIT: begin
                if (!pipe_stall) begin
                    br_resolved = 1'b1;
                    br_taken    = eval_taken;
                end
            end
            default: ;
        endcase
        if (!rst_n) begin
            flag_wen     = '0;
            hazard_stall = 1'b0;
            br_resolved  = 1'b0;
            br_taken     = 1'b0;
        end
    end

    assign flag_current = flag_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Bench for flag_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural model (honours FLAG_CTRL_FWD_EN).
`timescale 1ns/1ps
module tb_flag_ctrl;

    logic       clk;
    logic       rst_n;
    logic       pipe_stall;
    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic [2:0] ex_flags_in;
    logic       id_br_valid;
    logic [2:0] id_br_cond;
    logic [2:0] flag_current;
    logic [2:0] flag_wen;
    logic       br_resolved;
    logic       br_taken;
    logic       hazard_stall;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          run_cmp  = 1'b0;

    flag_ctrl #(
        .OPC_W    (4),
        .COND_W   (3),
        .FLAG_RST (3'b000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_stall   (pipe_stall),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_flags_in  (ex_flags_in),
        .id_br_valid  (id_br_valid),
        .id_br_cond   (id_br_cond),
        .flag_current (flag_current),
        .flag_wen     (flag_wen),
        .br_resolved  (br_resolved),
        .br_taken     (br_taken),
        .hazard_stall (hazard_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef FLAG_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    logic [2:0] m_flags;
    bit         m_owed;   // a stalled branch still owes its resolution

    function automatic logic [2:0] f_wen(input logic v, input logic st, input logic [3:0] opc);
        if (!v || st) return 3'b000;
        if (opc <= 4'd1) return 3'b111;
        if (opc == 4'd2 || opc == 4'd4 || opc == 4'd5 || opc == 4'd6) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic f_eval(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[0]; v = f[1]; n = f[2];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags = 3'b000;
            m_owed  = 1'b0;
        end else begin : model_step
            logic [2:0] w;
            bit haz;
            w   = f_wen(ex_valid, pipe_stall, ex_opcode);
            haz = id_br_valid && id_br_cond != 3'd7 && w != 3'b000;
            if (m_owed) m_owed = pipe_stall;
            else        m_owed = !FWD && haz;
            m_flags = (ex_flags_in & w) | (m_flags & ~w);
        end
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [2:0] w, eff;
        logic       e_res, e_tak, e_stl;
        bit         haz;
        if (run_cmp && rst_n === 1'b1) begin
            w     = f_wen(ex_valid, pipe_stall, ex_opcode);
            haz   = id_br_valid && id_br_cond != 3'd7 && w != 3'b000;
            eff   = FWD ? ((ex_flags_in & w) | (m_flags & ~w)) : m_flags;
            e_stl = 1'b0;
            if (m_owed) begin
                e_res = !pipe_stall;
                e_tak = !pipe_stall && f_eval(id_br_cond, m_flags);
            end else if (!FWD && haz) begin
                e_stl = 1'b1;
                e_res = 1'b0;
                e_tak = 1'b0;
            end else begin
                e_res = id_br_valid;
                e_tak = id_br_valid && f_eval(id_br_cond, eff);
            end
            chk("cmp_flag_current", flag_current, m_flags);
            chk("cmp_flag_wen", flag_wen, w);
            chk("cmp_br_resolved", {2'b0, br_resolved}, {2'b0, e_res});
            chk("cmp_br_taken", {2'b0, br_taken}, {2'b0, e_tak});
            chk("cmp_hazard_stall", {2'b0, hazard_stall}, {2'b0, e_stl});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        pipe_stall  = 1'b0;
        ex_valid    = 1'b0;
        ex_opcode   = 4'd0;
        ex_flags_in = 3'b000;
        id_br_valid = 1'b0;
        id_br_cond  = 3'd0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_ex(input logic [3:0] opc, input logic [2:0] f);
        ex_valid    = 1'b1;
        ex_opcode   = opc;
        ex_flags_in = f;
    endtask

    task automatic set_br(input logic [2:0] c);
        id_br_valid = 1'b1;
        id_br_cond  = c;
    endtask

    initial begin
        quiet();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        run_cmp = 1'b1;
        tick();

        // 1: reset while a branch is pending
        set_ex(4'd1, 3'b001);
        set_br(3'd1);
        #3;
        chk("t1_pre_stall", {2'b0, hazard_stall}, {2'b0, !FWD});
        tick();
        set_ex(4'd0, 3'b111);
        rst_n = 1'b0;
        #2;
        chk("t1_rst_flags", flag_current, 3'b000);
        chk("t1_rst_stall", {2'b0, hazard_stall}, 3'b000);
        chk("t1_rst_res", {2'b0, br_resolved}, 3'b000);
        chk("t1_rst_wen", flag_wen, 3'b000);
        ex_valid = 1'b0;
        set_br(3'd0);
        rst_n = 1'b1;
        #1;
        chk("t1_idle_res", {2'b0, br_resolved}, 3'b001);
        chk("t1_idle_taken", {2'b0, br_taken}, 3'b001);
        chk("t1_idle_stall", {2'b0, hazard_stall}, 3'b000);
        quiet();

        // 2: ADD writes all flags
        do_reset();
        set_ex(4'd0, 3'b111);
        #3;
        chk("t2_wen", flag_wen, 3'b111);
        tick();
        quiet();
        #3;
        chk("t2_flags", flag_current, 3'b111);

        // 3: XOR writes Z only
        do_reset();
        set_ex(4'd2, 3'b111);
        #3;
        chk("t3_wen", flag_wen, 3'b001);
        tick();
        quiet();
        #3;
        chk("t3_flags", flag_current, 3'b001);

        // 4: SUB Z=1 with an EQ branch
        do_reset();
        set_ex(4'd1, 3'b001);
        set_br(3'd1);
        #3;
        chk("t4_c0_stall", {2'b0, hazard_stall}, {2'b0, !FWD});
        chk("t4_c0_res", {2'b0, br_resolved}, {2'b0, FWD});
        chk("t4_c0_taken", {2'b0, br_taken}, {2'b0, FWD});
        tick();
        ex_valid = 1'b0;
        #3;
        chk("t4_c1_flags", flag_current, 3'b001);
        if (!FWD) begin
            chk("t4_c1_res", {2'b0, br_resolved}, 3'b001);
            chk("t4_c1_taken", {2'b0, br_taken}, 3'b001);
            chk("t4_c1_stall", {2'b0, hazard_stall}, 3'b000);
        end
        tick();
        quiet();

        // 5: SUB with an unconditional branch never stalls
        set_ex(4'd1, 3'b000);
        set_br(3'd7);
        #3;
        chk("t5_res", {2'b0, br_resolved}, 3'b001);
        chk("t5_taken", {2'b0, br_taken}, 3'b001);
        chk("t5_stall", {2'b0, hazard_stall}, 3'b000);
        tick();
        quiet();

        // 6: pipe_stall suppresses commit and hazard
        pipe_stall = 1'b1;
        set_ex(4'd0, 3'b110);
        set_br(3'd0);
        #3;
        chk("t6_wen", flag_wen, 3'b000);
        chk("t6_stall", {2'b0, hazard_stall}, 3'b000);
        chk("t6_res", {2'b0, br_resolved}, 3'b001);
        chk("t6_taken", {2'b0, br_taken}, 3'b001);
        tick();
        quiet();
        #3;
        chk("t6_flags", flag_current, 3'b000);

        // randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            pipe_stall  = ($urandom_range(0, 7) == 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_opcode   = 4'($urandom_range(0, 15));
            ex_flags_in = 3'($urandom_range(0, 7));
            id_br_valid = ($urandom_range(0, 1) == 1);
            id_br_cond  = 3'($urandom_range(0, 7));
        end
        tick();
        quiet();
        tick();
        run_cmp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
